fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller (one outstanding request, decode register, redirect/flush)
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   stallD                   decode cannot accept a new instruction
//   pc_srcE, pc_targetE      execute-stage redirect and its target
//   imem_req, imem_addr      memory request strobe and word address
//   imem_ready               memory accepts the request this cycle
//   imem_valid, imem_rdata   response strobe and instruction
//   instrD, pcD, validD      decode-stage instruction register
module fetch_ctrl #(
    parameter int              PC_W     = 5,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallD,
    input  logic            pc_srcE,
    input  logic [PC_W-1:0] pc_targetE,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instrD,
    output logic [PC_W-1:0] pcD,
    output logic            validD
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pcf_q, pcf_d;
    logic [PC_W-1:0] infl_q, infl_d;
    logic            kill_q, kill_d;
    logic [31:0]     hold_instr_q, hold_instr_d;
    logic [PC_W-1:0] hold_pc_q, hold_pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] pcd_q, pcd_d;
    logic            vd_q, vd_d;

    // Request is gated by reset so nothing is issued before the first post-reset cycle.
    assign imem_req  = rst && state_q == S_REQ && !pc_srcE;
    assign imem_addr = pcf_q;
    assign instrD    = instr_q;
    assign pcD       = pcd_q;
    assign validD    = vd_q;

    always_comb begin
        state_d      = state_q;
        pcf_d        = pcf_q;
        infl_d       = infl_q;
        kill_d       = kill_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        instr_d      = instr_q;
        pcd_d        = pcd_q;
        // An unloaded cycle drains D unless decode is stalled.
        vd_d         = vd_q && stallD;
        case (state_q)
            S_REQ: begin
                if (!pc_srcE && imem_ready) begin
                    infl_d  = pcf_q;
                    pcf_d   = pcf_q + 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_valid) begin
                    state_d = S_REQ;
                    kill_d  = 1'b0;
                    // A killed or redirected response is simply dropped.
                    if (!pc_srcE && !kill_q) begin
                        if (!vd_q || !stallD) begin
                            instr_d = imem_rdata;
                            pcd_d   = infl_q;
                            vd_d    = 1'b1;
                        end else begin
                            hold_instr_d = imem_rdata;
                            hold_pc_d    = infl_q;
                            state_d      = S_HOLD;
                        end
                    end
                end else if (pc_srcE) begin
                    // Response still in flight: remember to discard it when it lands.
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (pc_srcE) begin
                    state_d = S_REQ;
                end else if (!stallD) begin
                    instr_d = hold_instr_q;
                    pcd_d   = hold_pc_q;
                    vd_d    = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
        if (pc_srcE) begin
            pcf_d        = pc_targetE;
            vd_d         = 1'b0;
            hold_instr_d = '0;
            hold_pc_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_REQ;
            pcf_q        <= RESET_PC;
            infl_q       <= '0;
            kill_q       <= 1'b0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            instr_q      <= '0;
            pcd_q        <= '0;
            vd_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            infl_q       <= infl_d;
            kill_q       <= kill_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            instr_q      <= instr_d;
            pcd_q        <= pcd_d;
            vd_q         <= vd_d;
        end
    end
endmodule
